// File: rtl/fft_power_accumulator_pkg.sv
// Shared definitions for the FFT power accumulator: FSM state encoding and
// the width derivations used by the top, its interface and the testbench.
package fft_power_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // re^2 + im^2 needs one bit more than a single square.
    function automatic int pow_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    function automatic int acc_w(input int data_w, input int log2_avg);
        return pow_w(data_w) + log2_avg;
    endfunction

endpackage

// File: rtl/fft_power_accumulator_if.sv
// FFT sample input and averaged-bin output stream of the power accumulator.
// The master side drives samples and accepts bins; the slave side is the accumulator.
interface fft_power_accumulator_if
    import fft_power_accumulator_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    localparam int POW_W = pow_w(DATA_W);

    logic                     dv;
    logic signed [DATA_W-1:0] xk_re;
    logic signed [DATA_W-1:0] xk_im;
    logic        [ADDR_W-1:0] xk_index;

    logic                     out_valid;
    logic                     out_ready;
    logic        [POW_W-1:0]  out_data;
    logic        [ADDR_W-1:0] out_index;
    logic                     out_last;

    modport master (
        output dv, xk_re, xk_im, xk_index, out_ready,
        input  out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  dv, xk_re, xk_im, xk_index, out_ready,
        output out_valid, out_data, out_index, out_last
    );

endinterface

// File: rtl/fft_power_accumulator_acc_ram.sv
// Accumulator storage: one write port, one read port with a registered,
// enable-gated read so the read word holds until the next read is issued.
module acc_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 36
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: neither the array nor the read register is reset; that keeps it mappable to block RAM, and the first frame of every average overwrites each word anyway.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_power_accumulator.sv
// Averages |X(k)|^2 over 2^LOG2_AVG consecutive FFT frames per bin, then
// streams the averaged spectrum out over a valid/ready handshake.
module fft_power_accumulator
    import fft_power_accumulator_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int LOG2_AVG = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    fft_power_accumulator_if.slave bus,
    output logic                   busy,
    output logic                   overrun
);

    localparam int POW_W = pow_w(DATA_W);
    localparam int ACC_W = acc_w(DATA_W, LOG2_AVG);
    localparam int SQ_W  = 2 * DATA_W;

    state_t              state;
    logic [LOG2_AVG-1:0] frame_cnt;

    logic                     s1_valid;
    logic [SQ_W-1:0]          s1_sq_re;
    logic [SQ_W-1:0]          s1_sq_im;
    logic [ADDR_W-1:0]        s1_idx;
    logic                     s2_valid;
    logic [POW_W-1:0]         s2_pow;
    logic [ACC_W-1:0]         s2_q;
    logic [ADDR_W-1:0]        s2_idx;
    logic signed [SQ_W-1:0]   re_ext;
    logic signed [SQ_W-1:0]   im_ext;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACC_W-1:0]  rd_data;
    logic              wr_en;
    logic [ACC_W-1:0]  wr_data;

    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_done;
    logic              q_valid;
    logic [ADDR_W-1:0] q_idx;
    logic              out_valid;
    logic [POW_W-1:0]  out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;

    logic accept;
    logic frame_end;
    logic drain_enter;
    logic load_out;
    logic drain_issue;

    // Frames start only on bin 0; anything else seen while idle is dropped.
    assign accept      = bus.dv && ((state == ST_ACCUM) ||
                                    (state == ST_IDLE && bus.xk_index == '0));
    assign frame_end   = s2_valid && (s2_idx == '1);
    assign drain_enter = (state == ST_ACCUM) && frame_end && (frame_cnt == '1);

    // The RAM read word acts as a one-entry buffer ahead of the output register.
    assign load_out    = q_valid && (!out_valid || bus.out_ready);
    assign drain_issue = (state == ST_DRAIN) && !rd_done && (!q_valid || load_out);

    assign rd_en   = accept || drain_issue;
    assign rd_addr = (state == ST_DRAIN) ? rd_ptr : bus.xk_index;
    assign wr_en   = s2_valid;
    assign wr_data = (frame_cnt == '0) ? ACC_W'(s2_pow) : s2_q + ACC_W'(s2_pow);

    assign re_ext = SQ_W'(bus.xk_re);
    assign im_ext = SQ_W'(bus.xk_im);

    acc_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ACC_W)
    ) u_acc_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (s2_idx),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // NOTE: non-blocking assignments throughout, so each stage captures the previous stage's pre-edge value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sq_re <= '0;
            s1_sq_im <= '0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_pow   <= '0;
            s2_q     <= '0;
            s2_idx   <= '0;
        end else begin
            s1_valid <= accept && !drain_enter;
            s2_valid <= s1_valid && !drain_enter;
            if (accept) begin
                s1_sq_re <= re_ext * re_ext;
                s1_sq_im <= im_ext * im_ext;
                s1_idx   <= bus.xk_index;
            end
            if (s1_valid) begin
                s2_pow <= POW_W'(s1_sq_re) + POW_W'(s1_sq_im);
                s2_q   <= rd_data;
                s2_idx <= s1_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
            rd_ptr    <= '0;
            rd_done   <= 1'b0;
            q_valid   <= 1'b0;
            q_idx     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bus.dv && state == ST_DRAIN) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (frame_end) begin
                        if (frame_cnt == '1) begin
                            state     <= ST_DRAIN;
                            frame_cnt <= '0;
                            rd_ptr    <= '0;
                            rd_done   <= 1'b0;
                            q_valid   <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + LOG2_AVG'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_issue) begin
                        q_idx  <= rd_ptr;
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                        if (rd_ptr == '1) rd_done <= 1'b1;
                    end
                    q_valid <= drain_issue || (q_valid && !load_out);
                    if (out_valid && bus.out_ready && out_last) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (load_out) begin
                        out_valid <= 1'b1;
                        out_data  <= POW_W'(rd_data >> LOG2_AVG);
                        out_index <= q_idx;
                        out_last  <= (q_idx == '1);
                    end else if (out_valid && bus.out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (state == ST_DRAIN);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_index = out_index;
    assign bus.out_last  = out_last;

endmodule

// File: tb/tb_fft_power_accumulator.sv
// Scoreboard bench: stimulus accumulates per-bin power sums in a reference
// array and queues the averaged spectrum; a monitor checks each transferred bin.
module tb_fft_power_accumulator;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 10;
    localparam int LOG2_AVG = 3;
    localparam int N        = 1 << ADDR_W;
    localparam int FRAMES   = 1 << LOG2_AVG;

    typedef struct {
        longint data;
        int     index;
        bit     last;
    } bin_t;

    logic clock = 1'b0;
    logic reset;
    logic busy;
    logic overrun;

    fft_power_accumulator_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fft_power_accumulator #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LOG2_AVG (LOG2_AVG)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    bin_t   exp_q[$];
    longint model[N];
    int     n_pass     = 0;
    int     n_total    = 0;
    int     ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        for (int b = 0; b < N; b++) model[b] = 0;
    endtask

    // The average of a bin is the sum of its powers over all frames divided by the frame count.
    task automatic model_publish();
        bin_t e;
        for (int b = 0; b < N; b++) begin
            e.data  = model[b] / FRAMES;
            e.index = b;
            e.last  = (b == N - 1);
            exp_q.push_back(e);
        end
        model_clear();
    endtask

    task automatic drive(input bit v, input int re, input int im, input int idx);
        @(posedge clock);
        #1;
        bus.dv       = v;
        bus.xk_re    = DATA_W'(re);
        bus.xk_im    = DATA_W'(im);
        bus.xk_index = ADDR_W'(idx);
    endtask

    task automatic idle_cycle();
        drive(1'b0, int'($urandom), int'($urandom), int'($urandom));
    endtask

    // pat 0: 3+4j everywhere; 1: full-scale on bin 5 only; 2: re = frame number; 3: random with dv gaps
    task automatic send_frame(input int pat, input int k);
        for (int b = 0; b < N; b++) begin
            int re;
            int im;
            case (pat)
                0: begin re = 3; im = 4; end
                1: begin re = (b == 5) ? -32768 : 0; im = re; end
                2: begin re = k; im = 0; end
                default: begin
                    re = int'($urandom_range(0, 65535)) - 32768;
                    im = int'($urandom_range(0, 65535)) - 32768;
                end
            endcase
            if (pat == 3) while ($urandom_range(0, 3) == 0) idle_cycle();
            drive(1'b1, re, im, b);
            model[b] += longint'(re) * re + longint'(im) * im;
        end
    endtask

    task automatic send_average(input int pat);
        for (int k = 0; k < FRAMES; k++) send_frame(pat, k);
        model_publish();
        drive(1'b0, 0, 0, 0);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        check(name, busy, 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 8000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_complete"}, (n < 8000), 1);
        repeat (2) @(negedge clock);
        check({name, "_busy_low"}, busy, 0);
        check({name, "_valid_low"}, bus.out_valid, 0);
    endtask

    task automatic measure_drain(input string name);
        int cyc = 0;
        int lat = -1;
        wait_busy({name, "_busy"});
        while (busy && cyc < 4 * N) begin
            if (lat < 0 && bus.out_valid) lat = cyc;
            cyc++;
            @(negedge clock);
        end
        check({name, "_first_valid"}, (lat >= 0 && lat <= 2), 1);
        check({name, "_drain_cycles"}, (cyc <= N + 2), 1);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_out_valid"}, bus.out_valid, 0);
        check({name, "_out_data"},  bus.out_data,  0);
        check({name, "_out_index"}, bus.out_index, 0);
        check({name, "_out_last"},  bus.out_last,  0);
        check({name, "_busy"},      busy,          0);
        check({name, "_overrun"},   overrun,       0);
    endtask

    // Downstream ready: always 1, or the repeating pattern 1,0,0,1.
    initial begin
        int pc;
        pc = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = (pc == 0 || pc == 3);
                pc = (pc + 1) % 4;
            end
        end
    end

    // Monitor: pops one expected bin per transfer and checks stalled outputs hold.
    initial begin
        bin_t        e;
        logic        stalled;
        logic [63:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("stall_hold", {bus.out_valid, bus.out_last, bus.out_index, bus.out_data}, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_bin: got index %0d, expected no output", bus.out_index);
                    end else begin
                        e = exp_q.pop_front();
                        check("bin_index", bus.out_index, e.index);
                        check("bin_data",  bus.out_data,  e.data);
                        check("bin_last",  bus.out_last,  e.last);
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = {bus.out_valid, bus.out_last, bus.out_index, bus.out_data};
            end
        end
    end

    initial begin
        bus.dv       = 1'b0;
        bus.xk_re    = '0;
        bus.xk_im    = '0;
        bus.xk_index = '0;
        reset        = 1'b1;
        model_clear();
        repeat (3) @(negedge clock);
        check_reset_state("por");
        reset = 1'b0;

        send_average(0);
        measure_drain("const_3_4");
        wait_drain("const_3_4");
        check("overrun_quiet", overrun, 0);

        send_average(1);
        wait_drain("full_scale_bin5");

        send_average(2);
        wait_drain("ramp_frames");

        // Nonzero-index samples while idle must not start or pollute an average.
        ready_mode = 1;
        repeat (5) drive(1'b1, int'($urandom), int'($urandom), int'($urandom_range(1, N - 1)));
        send_average(3);
        wait_drain("random_stalled");
        ready_mode = 0;

        send_average(2);
        wait_busy("overrun_run_busy");
        drive(1'b1, int'($urandom), int'($urandom), 0);
        drive(1'b0, 0, 0, 0);
        @(negedge clock);
        check("overrun_set", overrun, 1);
        wait_drain("overrun_run");
        check("overrun_sticky", overrun, 1);

        for (int k = 0; k < 3; k++) send_frame(3, k);
        model_clear();
        @(posedge clock);
        #1;
        bus.dv = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        check_reset_state("mid_accum_reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("after_reset");
        send_average(3);
        wait_drain("fresh_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
